axi_stream_slave: RTL and testbench

- AXI-Stream receiver: the sink end of the `axi_if` link driven by `axi_stream_master`.
- Accepts 32-bit beats via `tvalid`/`tready`, buffers them in a small first-word-fall-through (FWFT) FIFO, and presents them to downstream frequency-meter logic with a valid/ready handshake.
- Tracks packet boundaries via `tlast` and flags completed packets.

---
 rtl/axis_pkg.sv | 16 +
 rtl/axi_if.sv | 12 +
 rtl/axis_fwft_fifo.sv | 54 +++++
 rtl/axi_stream_slave.sv | 82 ++++++++
 tb/tb_axi_stream_slave.sv | 296 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/axis_pkg.sv
// rtl/axis_pkg.sv - shared types and widths for the AXI-Stream receive path
package axis_pkg;

  localparam int DATA_W = 32;

  typedef struct packed {
    logic              last;
    logic [DATA_W-1:0] data;
  } axis_beat_t;

  typedef enum logic {
    IDLE   = 1'b0,
    IN_PKT = 1'b1
  } axis_rx_state_t;

endpackage

// File: rtl/axi_if.sv
// rtl/axi_if.sv - AXI-Stream link between axi_stream_master and axi_stream_slave
interface axi_if #(
  parameter int DATA_W = 32
);
  logic [DATA_W-1:0] tdata;
  logic              tvalid;
  logic              tlast;
  logic              tready;

  modport master (output tdata, output tvalid, output tlast, input tready);
  modport slave  (input tdata, input tvalid, input tlast, output tready);
endinterface

// File: rtl/axis_fwft_fifo.sv
// rtl/axis_fwft_fifo.sv - first-word-fall-through FIFO, head word visible without a read strobe
module axis_fwft_fifo #(
  parameter int WIDTH = 33,
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [WIDTH-1:0] last_pop;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // When empty the last popped word stays on the output instead of stale storage.
  assign pop_data = empty ? last_pop : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      last_pop <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop) begin
        rd_ptr   <= rd_ptr + 1'b1;
        last_pop <= mem[rd_ptr];
      end
      if (do_push && !do_pop)      count <= count + 1'b1;
      else if (do_pop && !do_push) count <= count - 1'b1;
    end
  end

endmodule

// File: rtl/axi_stream_slave.sv
// rtl/axi_stream_slave.sv - AXI-Stream sink with FWFT buffer and packet tracking
// Optional beat/packet counters are built when AXIS_SLAVE_STATS_EN is defined.
module axi_stream_slave #(
  parameter int DATA_W = axis_pkg::DATA_W,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst,
  axi_if.slave              axi,
  output logic [DATA_W-1:0] data_out,
  output logic              last_out,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              pkt_done,
  output logic              in_packet
`ifdef AXIS_SLAVE_STATS_EN
  ,
  output logic [31:0]       beat_cnt,
  output logic [15:0]       pkt_cnt
`endif
);
  import axis_pkg::*;

  localparam int CW = $clog2(DEPTH) + 1;

  axis_beat_t     wr_beat;
  axis_beat_t     head;
  logic           fifo_full;
  logic           fifo_empty;
  logic [CW-1:0]  fifo_count;
  logic           push;
  logic           pop;
  axis_rx_state_t state;

  // tready comes from registered occupancy only, never from tvalid.
  assign axi.tready = (fifo_count != CW'(DEPTH)) && !rst;
  assign push       = axi.tvalid && !fifo_full;
  assign pop        = out_valid && out_ready;
  assign out_valid  = !fifo_empty;
  assign wr_beat    = '{last: axi.tlast, data: axi.tdata};
  assign data_out   = head.data;
  assign last_out   = head.last;
  assign in_packet  = (state == IN_PKT);

  axis_fwft_fifo #(
    .WIDTH ($bits(axis_beat_t)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (wr_beat),
    .pop       (pop),
    .pop_data  (head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      pkt_done <= 1'b0;
    end else begin
      pkt_done <= push && axi.tlast;
      if (push) state <= axi.tlast ? IDLE : IN_PKT;
    end
  end

`ifdef AXIS_SLAVE_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      beat_cnt <= '0;
      pkt_cnt  <= '0;
    end else if (push) begin
      beat_cnt <= beat_cnt + 1'b1;
      if (axi.tlast) pkt_cnt <= pkt_cnt + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_axi_stream_slave.sv
// tb/tb_axi_stream_slave.sv - scoreboard bench for axi_stream_slave
`timescale 1ns/1ps
module tb_axi_stream_slave;
  import axis_pkg::*;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] data_out;
  logic        last_out;
  logic        out_valid;
  logic        out_ready;
  logic        pkt_done;
  logic        in_packet;
`ifdef AXIS_SLAVE_STATS_EN
  logic [31:0] beat_cnt;
  logic [15:0] pkt_cnt;
`endif

  int n_cmp = 0;
  int n_bad = 0;
  int m_beats = 0;
  int m_pkts = 0;
  axis_beat_t sb[$];

  always #5 clk = ~clk;

  axi_if #(.DATA_W(32)) axi ();

  axi_stream_slave #(.DATA_W(32), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .axi       (axi),
    .data_out  (data_out),
    .last_out  (last_out),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .pkt_done  (pkt_done),
    .in_packet (in_packet)
`ifdef AXIS_SLAVE_STATS_EN
    ,
    .beat_cnt  (beat_cnt),
    .pkt_cnt   (pkt_cnt)
`endif
  );

  // Called just before an edge: records the handshakes that edge will perform.
  task automatic sb_step(output logic popped, output axis_beat_t exp, output logic pushed);
    popped = out_valid && out_ready;
    pushed = axi.tvalid && axi.tready;
    exp = '{last: 1'b1, data: 32'hEEEE_0000};
    if (popped && sb.size() != 0) exp = sb.pop_front();
    if (pushed) begin
      sb.push_back('{last: axi.tlast, data: axi.tdata});
      m_beats++;
      if (axi.tlast) m_pkts++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; axi.tvalid = 1'b1; axi.tdata = 32'h0BAD_F00D; axi.tlast = 1'b0; out_ready = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if ({axi.tready, out_valid, pkt_done, in_packet, last_out, data_out} !== {5'b0, 32'h0}) begin
      n_bad++;
      $display("FAIL reset_state: got tready=%b out_valid=%b pkt_done=%b in_packet=%b last=%b data=%h required all 0",
               axi.tready, out_valid, pkt_done, in_packet, last_out, data_out);
    end
`ifdef AXIS_SLAVE_STATS_EN
    n_cmp++;
    if (beat_cnt !== 32'd0 || pkt_cnt !== 16'd0) begin
      n_bad++; $display("FAIL reset_stats: got %0d/%0d required 0/0", beat_cnt, pkt_cnt);
    end
`endif
    @(posedge clk); #1;
    rst = 1'b0; axi.tvalid = 1'b0;
    sb.delete(); m_beats = 0; m_pkts = 0;
    @(negedge clk);
    n_cmp++;
    if (axi.tready !== 1'b1 || out_valid !== 1'b0) begin
      n_bad++; $display("FAIL reset_release: got tready=%b out_valid=%b required 1/0", axi.tready, out_valid);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_single_beat();
    logic popped, pushed;
    axis_beat_t exp;
    axi.tvalid = 1'b1; axi.tdata = 32'hAABB_CCDD; axi.tlast = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    sb_step(popped, exp, pushed);
    n_cmp++;
    if (pushed !== 1'b1) begin n_bad++; $display("FAIL single_accept: got %b required 1", pushed); end
    @(posedge clk); #1;
    axi.tvalid = 1'b0; axi.tdata = 32'hFFFF_FFFF; axi.tlast = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({out_valid, pkt_done, in_packet} !== 3'b110) begin
      n_bad++; $display("FAIL single_flags: got valid/done/inpkt=%b%b%b required 110", out_valid, pkt_done, in_packet);
    end
    sb_step(popped, exp, pushed);
    n_cmp++;
    if (!popped || {last_out, data_out} !== exp) begin
      n_bad++; $display("FAIL single_data: got %b %h required %b %h", last_out, data_out, exp.last, exp.data);
    end
    @(posedge clk); #1;
    @(negedge clk);
    n_cmp++;
    if ({out_valid, pkt_done, in_packet, last_out, data_out} !== {3'b000, 1'b1, 32'hAABB_CCDD}) begin
      n_bad++; $display("FAIL single_after: got valid=%b done=%b inpkt=%b hold=%b %h required 0 0 0 1 aabbccdd",
                        out_valid, pkt_done, in_packet, last_out, data_out);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_backpressure();
    logic popped, pushed, got5;
    axis_beat_t exp;
    int pops;
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      axi.tvalid = 1'b1; axi.tdata = 32'(i + 1); axi.tlast = 1'b0;
      @(negedge clk);
      n_cmp++;
      if (axi.tready !== 1'b1) begin n_bad++; $display("FAIL fill_tready: beat %0d got %b required 1", i, axi.tready); end
      sb_step(popped, exp, pushed);
      @(posedge clk); #1;
    end
    axi.tdata = 32'h5; axi.tlast = 1'b1;
    repeat (3) begin
      @(negedge clk);
      n_cmp++;
      if ({axi.tready, out_valid, data_out} !== {2'b01, 32'h1}) begin
        n_bad++; $display("FAIL full_hold: got tready=%b valid=%b data=%h required 0 1 00000001", axi.tready, out_valid, data_out);
      end
      sb_step(popped, exp, pushed);
      @(posedge clk); #1;
    end
    out_ready = 1'b1; pops = 0; got5 = 1'b0;
    for (int c = 0; c < 20 && pops < 5; c++) begin
      @(negedge clk);
      if (c < 2) begin
        n_cmp++;
        if (axi.tready !== (c == 1)) begin n_bad++; $display("FAIL drain_tready: cycle %0d got %b required %b", c, axi.tready, c == 1); end
      end
      sb_step(popped, exp, pushed);
      if (popped) begin
        pops++;
        n_cmp++;
        if ({last_out, data_out} !== exp) begin
          n_bad++; $display("FAIL drain_data: got %b %h required %b %h", last_out, data_out, exp.last, exp.data);
        end
      end
      @(posedge clk); #1;
      if (pushed) begin axi.tvalid = 1'b0; got5 = 1'b1; end
    end
    n_cmp++;
    if (pops != 5 || !got5) begin n_bad++; $display("FAIL drain_done: got pops=%0d got5=%b required 5 1", pops, got5); end
  endtask

  task automatic test_multi_beat();
    logic popped, pushed;
    axis_beat_t exp;
    logic [31:0] beats [3];
    int dones;
    beats[0] = 32'h1234_1234; beats[1] = 32'h55AA_55AA; beats[2] = 32'hDEAD_BEEF;
    out_ready = 1'b1; dones = 0;
    for (int i = 0; i < 3; i++) begin
      axi.tvalid = 1'b1; axi.tdata = beats[i]; axi.tlast = (i == 2);
      @(negedge clk);
      n_cmp++;
      if (axi.tready !== 1'b1) begin n_bad++; $display("FAIL multi_tready: beat %0d got %b required 1", i, axi.tready); end
      dones += int'(pkt_done);
      sb_step(popped, exp, pushed);
      @(posedge clk); #1;
      axi.tvalid = 1'b0;
      @(negedge clk);
      n_cmp++;
      if (in_packet !== (i != 2)) begin n_bad++; $display("FAIL multi_in_packet: beat %0d got %b required %b", i, in_packet, i != 2); end
      dones += int'(pkt_done);
      sb_step(popped, exp, pushed);
      n_cmp++;
      if (!popped || {last_out, data_out} !== exp) begin
        n_bad++; $display("FAIL multi_data: got %b %h required %b %h", last_out, data_out, exp.last, exp.data);
      end
      @(posedge clk); #1;
    end
    n_cmp++;
    if (dones != 1) begin n_bad++; $display("FAIL multi_pkt_done: got %0d pulses required 1", dones); end
  endtask

  task automatic test_stress();
    logic popped, pushed, last_v, st_model, pd_model;
    axis_beat_t exp;
    int sent, recv;
    sent = 0; recv = 0; st_model = 1'b0; pd_model = 1'b0;
    axi.tvalid = 1'b0;
    for (int c = 0; c < 20000 && (sent < 1000 || sb.size() != 0); c++) begin
      if (!axi.tvalid && sent < 1000 && $urandom_range(0, 9) < 8) begin
        axi.tvalid = 1'b1; axi.tdata = $urandom;
        axi.tlast = (sent == 999) || ($urandom_range(0, 3) == 0);
      end
      out_ready = ($urandom_range(0, 9) < 7);
      @(negedge clk);
      n_cmp++;
      if ({axi.tready, out_valid, in_packet, pkt_done} !== {sb.size() < DEPTH, sb.size() != 0, st_model, pd_model}) begin
        n_bad++; $display("FAIL stress_ctl: cycle %0d got rdy/vld/inpkt/done=%b%b%b%b required %b%b%b%b", c,
                          axi.tready, out_valid, in_packet, pkt_done, sb.size() < DEPTH, sb.size() != 0, st_model, pd_model);
      end
      last_v = axi.tlast;
      sb_step(popped, exp, pushed);
      if (popped) begin
        recv++;
        n_cmp++;
        if ({last_out, data_out} !== exp) begin
          n_bad++; $display("FAIL stress_data: beat %0d got %b %h required %b %h", recv, last_out, data_out, exp.last, exp.data);
        end
      end
      if (sb.size() > DEPTH) begin
        n_cmp++; n_bad++; $display("FAIL stress_occupancy: got %0d required <= %0d", sb.size(), DEPTH);
      end
      pd_model = pushed && last_v;
      if (pushed) st_model = !last_v;
      @(posedge clk); #1;
      if (pushed) begin sent++; axi.tvalid = 1'b0; end
    end
    n_cmp++;
    if (sent != 1000 || recv != 1000) begin n_bad++; $display("FAIL stress_done: got sent=%0d recv=%0d required 1000/1000", sent, recv); end
`ifdef AXIS_SLAVE_STATS_EN
    n_cmp++;
    if (beat_cnt !== 32'(m_beats) || pkt_cnt !== 16'(m_pkts)) begin
      n_bad++; $display("FAIL stress_stats: got %0d/%0d required %0d/%0d", beat_cnt, pkt_cnt, m_beats, m_pkts);
    end
`endif
  endtask

  task automatic test_mid_reset();
    logic popped, pushed;
    axis_beat_t exp;
    out_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      axi.tvalid = 1'b1; axi.tdata = 32'h100 + 32'(i); axi.tlast = 1'b0;
      @(negedge clk);
      sb_step(popped, exp, pushed);
      @(posedge clk); #1;
    end
    axi.tvalid = 1'b1; axi.tdata = 32'h102;
    @(negedge clk);
    n_cmp++;
    if ({in_packet, out_valid} !== 2'b11) begin n_bad++; $display("FAIL mid_before: got inpkt/valid=%b%b required 11", in_packet, out_valid); end
    rst = 1'b1;
    #1;
    n_cmp++;
    if ({out_valid, in_packet, axi.tready} !== 3'b000) begin
      n_bad++; $display("FAIL mid_reset_now: got valid/inpkt/tready=%b%b%b required 000", out_valid, in_packet, axi.tready);
    end
`ifdef AXIS_SLAVE_STATS_EN
    n_cmp++;
    if (beat_cnt !== 32'd0) begin n_bad++; $display("FAIL mid_reset_stats: got %0d required 0", beat_cnt); end
`endif
    @(posedge clk); #1;
    @(negedge clk);
    n_cmp++;
    if (pkt_done !== 1'b0) begin n_bad++; $display("FAIL mid_reset_done: got %b required 0", pkt_done); end
    @(posedge clk); #1;
    rst = 1'b0; axi.tvalid = 1'b0;
    sb.delete(); m_beats = 0; m_pkts = 0;
    axi.tvalid = 1'b1; axi.tdata = 32'hCAFE_0001; axi.tlast = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    sb_step(popped, exp, pushed);
    @(posedge clk); #1;
    axi.tvalid = 1'b0;
    @(negedge clk);
    sb_step(popped, exp, pushed);
    n_cmp++;
    if (!popped || {last_out, data_out, pkt_done, in_packet} !== {exp, 2'b10}) begin
      n_bad++; $display("FAIL mid_recover: got %b %h done=%b inpkt=%b required %b %h 1 0",
                        last_out, data_out, pkt_done, in_packet, exp.last, exp.data);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset();
    test_single_beat();
    test_backpressure();
    test_multi_beat();
    test_stress();
    test_mid_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
